rng_request_arbiter: RTL and testbench

//  Shares one Random_seed_generator (MT19937 core) among NUM_REQ client blocks. Round-robin grants
//  one request at a time, runs the core's en until one number completes, then returns it to the

---
 rtl/rng_arb_pkg.sv | 16 +
 rtl/rng_rr_pick.sv | 30 +++
 rtl/rng_request_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_rng_request_arbiter.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rng_arb_pkg.sv
// Shared FSM encoding and constants for the RNG request arbiter and its picker.
package rng_arb_pkg;

    typedef enum logic [1:0] {
        ST_RESEED  = 2'd0,
        ST_IDLE    = 2'd1,
        ST_RUN     = 2'd2,
        ST_DELIVER = 2'd3
    } arb_state_e;

    // Core state value that marks a freshly produced number.
    localparam logic [7:0]  GEN_DONE_STATE = 8'd100;
    localparam int          RESEED_CYCLES  = 2;
    localparam logic [31:0] DEFAULT_SEED   = 32'd200;

endpackage : rng_arb_pkg

// File: rtl/rng_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping to 0.
// Zero latency; produces both a one-hot grant and its index.
module rng_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [PTR_W-1:0]   gnt_idx_o,
    output logic               any_o
);

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int idx;
            idx = int'(ptr_i) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!any_o && req_i[idx]) begin
                any_o      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = PTR_W'(idx);
            end
        end
    end

endmodule : rng_rr_pick

// File: rtl/rng_request_arbiter.sv
// Shares one MT19937 core among NUM_REQ clients: round-robin grant, run core until a word is done, deliver it.
// Also sequences core reseeding. Optional RUN watchdog when RNG_TIMEOUT_EN is defined.
module rng_request_arbiter #(
    parameter int                NUM_REQ      = 4,
    parameter int                DATA_W       = 32,
    parameter logic [DATA_W-1:0] DEFAULT_SEED = DATA_W'(rng_arb_pkg::DEFAULT_SEED),
    parameter int                TIMEOUT      = 8191
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] rsp_valid,
    output logic [DATA_W-1:0]  rsp_data,
    input  logic               reseed_req,
    input  logic [DATA_W-1:0]  reseed_val,
    output logic               busy,
    output logic               gen_rst,
    output logic               gen_en,
    output logic [DATA_W-1:0]  gen_seed,
    input  logic [7:0]         gen_state,
    input  logic [DATA_W-1:0]  gen_result,
    output logic               timeout_err
);

    import rng_arb_pkg::*;

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int RS_W  = (RESEED_CYCLES > 1) ? $clog2(RESEED_CYCLES) : 1;

    arb_state_e         state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0] grant_oh_q, grant_oh_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic [DATA_W-1:0]  seed_q, seed_d;
    logic [DATA_W-1:0]  reseed_val_q, reseed_val_d;
    logic               reseed_pend_q, reseed_pend_d;
    logic               gen_rst_q, gen_rst_d;
    logic               gen_en_q, gen_en_d;
    logic               run_first_q, run_first_d;
    logic [RS_W-1:0]    rs_cnt_q, rs_cnt_d;

    logic [NUM_REQ-1:0] pick_req;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_any;
    logic               gen_done;

`ifdef RNG_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout_err_q, timeout_err_d;
    logic            force_reseed_q, force_reseed_d;
`endif

    // A client that is just being answered may still show req this cycle; don't regrant it.
    assign pick_req = req & ~rsp_valid_q;

    rng_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req_i     (pick_req),
        .ptr_i     (ptr_q),
        .gnt_o     (pick_gnt),
        .gnt_idx_o (pick_idx),
        .any_o     (pick_any)
    );

    // The core may still be parked at the done state on the first RUN cycle; ignore that cycle.
    assign gen_done = gen_en_q && !run_first_q && (gen_state == GEN_DONE_STATE);

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_d       = grant_q;
        grant_oh_d    = grant_oh_q;
        rsp_valid_d   = '0;
        rsp_data_d    = rsp_data_q;
        seed_d        = seed_q;
        reseed_val_d  = reseed_val_q;
        reseed_pend_d = reseed_pend_q;
        gen_rst_d     = gen_rst_q;
        gen_en_d      = gen_en_q;
        run_first_d   = run_first_q;
        rs_cnt_d      = rs_cnt_q;
`ifdef RNG_TIMEOUT_EN
        to_cnt_d       = to_cnt_q;
        timeout_err_d  = timeout_err_q;
        force_reseed_d = force_reseed_q;
`endif

        if (reseed_req && state_q != ST_IDLE) begin
            reseed_pend_d = 1'b1;
            reseed_val_d  = reseed_val;
        end

        case (state_q)
            ST_RESEED: begin
                gen_rst_d = 1'b1;
                gen_en_d  = 1'b0;
                if (rs_cnt_q == RS_W'(RESEED_CYCLES - 1)) begin
                    rs_cnt_d  = '0;
                    gen_rst_d = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    rs_cnt_d = rs_cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (reseed_req || reseed_pend_q) begin
                    seed_d        = reseed_req ? reseed_val : reseed_val_q;
                    reseed_pend_d = 1'b0;
                    gen_rst_d     = 1'b1;
                    rs_cnt_d      = '0;
                    state_d       = ST_RESEED;
                end else if (pick_any) begin
                    grant_d     = pick_idx;
                    grant_oh_d  = pick_gnt;
                    gen_en_d    = 1'b1;
                    run_first_d = 1'b1;
`ifdef RNG_TIMEOUT_EN
                    to_cnt_d    = '0;
`endif
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                run_first_d = 1'b0;
                if (gen_done) begin
                    rsp_data_d = gen_result;
                    gen_en_d   = 1'b0;
                    state_d    = ST_DELIVER;
                end
`ifdef RNG_TIMEOUT_EN
                else if (to_cnt_q == TO_W'(TIMEOUT)) begin
                    rsp_data_d     = '0;
                    gen_en_d       = 1'b0;
                    timeout_err_d  = 1'b1;
                    force_reseed_d = 1'b1;
                    state_d        = ST_DELIVER;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end
            ST_DELIVER: begin
                rsp_valid_d = grant_oh_q;
                ptr_d       = (grant_q == PTR_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                state_d     = ST_IDLE;
`ifdef RNG_TIMEOUT_EN
                // A hung core gets reinitialised with the seed it already had.
                if (force_reseed_q) begin
                    force_reseed_d = 1'b0;
                    gen_rst_d      = 1'b1;
                    rs_cnt_d       = '0;
                    state_d        = ST_RESEED;
                end
`endif
            end
            default: state_d = ST_RESEED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RESEED;
            ptr_q         <= '0;
            grant_q       <= '0;
            grant_oh_q    <= '0;
            rsp_valid_q   <= '0;
            rsp_data_q    <= '0;
            seed_q        <= DEFAULT_SEED;
            reseed_val_q  <= '0;
            reseed_pend_q <= 1'b0;
            gen_rst_q     <= 1'b1;
            gen_en_q      <= 1'b0;
            run_first_q   <= 1'b0;
            rs_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_q       <= grant_d;
            grant_oh_q    <= grant_oh_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            seed_q        <= seed_d;
            reseed_val_q  <= reseed_val_d;
            reseed_pend_q <= reseed_pend_d;
            gen_rst_q     <= gen_rst_d;
            gen_en_q      <= gen_en_d;
            run_first_q   <= run_first_d;
            rs_cnt_q      <= rs_cnt_d;
        end
    end

`ifdef RNG_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q       <= '0;
            timeout_err_q  <= 1'b0;
            force_reseed_q <= 1'b0;
        end else begin
            to_cnt_q       <= to_cnt_d;
            timeout_err_q  <= timeout_err_d;
            force_reseed_q <= force_reseed_d;
        end
    end
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != ST_IDLE);
    assign gen_rst   = gen_rst_q;
    assign gen_en    = gen_en_q;
    assign gen_seed  = seed_q;

endmodule : rng_request_arbiter

// File: tb/tb_rng_request_arbiter.sv
// Bench for rng_request_arbiter: behavioural MT19937 core plus a scoreboard of expected deliveries.
module tb_rng_request_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int DATA_W   = 32;
    localparam int CORE_LAT = 3;
    localparam int BUDGET   = 300;
`ifdef RNG_TIMEOUT_EN
    localparam int TB_TIMEOUT = 50;
`else
    localparam int TB_TIMEOUT = 8191;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] rsp_valid;
    logic [DATA_W-1:0]  rsp_data;
    logic               reseed_req;
    logic [DATA_W-1:0]  reseed_val;
    logic               busy;
    logic               gen_rst;
    logic               gen_en;
    logic [DATA_W-1:0]  gen_seed;
    logic [7:0]         gen_state  = '0;
    logic [DATA_W-1:0]  gen_result = '0;
    logic               timeout_err;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int          client;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] ref_seed = 32'd200;
    int          ref_k    = 0;

    always #5 clk = ~clk;

    rng_request_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .DATA_W       (DATA_W),
        .DEFAULT_SEED (32'd200),
        .TIMEOUT      (TB_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .reseed_req  (reseed_req),
        .reseed_val  (reseed_val),
        .busy        (busy),
        .gen_rst     (gen_rst),
        .gen_en      (gen_en),
        .gen_seed    (gen_seed),
        .gen_state   (gen_state),
        .gen_result  (gen_result),
        .timeout_err (timeout_err)
    );

    // n-th tempered output (n < 624) of MT19937 seeded with seed.
    function automatic logic [31:0] mt_nth(input logic [31:0] seed, input int n);
        logic [31:0] mt [624];
        logic [31:0] y;
        mt[0] = seed;
        for (int i = 1; i < 624; i++)
            mt[i] = 32'd1812433253 * (mt[i-1] ^ (mt[i-1] >> 30)) + 32'(i);
        for (int i = 0; i < 624; i++) begin
            y = (mt[i] & 32'h8000_0000) | (mt[(i + 1) % 624] & 32'h7fff_ffff);
            mt[i] = mt[(i + 397) % 624] ^ (y >> 1) ^ (y[0] ? 32'h9908_b0df : 32'h0);
        end
        y = mt[n];
        y = y ^ (y >> 11);
        y = y ^ ((y << 7) & 32'h9d2c_5680);
        y = y ^ ((y << 15) & 32'hefc6_0000);
        y = y ^ (y >> 18);
        return y;
    endfunction

    // Core model: synchronous active-high reset samples the seed, produces a word every few enabled cycles.
    logic [31:0] core_seed  = '0;
    int          core_k     = 0;
    int          core_cnt   = 0;
    bit          core_stuck = 1'b0;

    always @(posedge clk) begin
        if (gen_rst) begin
            core_seed <= gen_seed;
            core_k    <= 0;
            core_cnt  <= 0;
            gen_state <= 8'd0;
        end else if (core_stuck) begin
            gen_state <= 8'd0;
        end else if (gen_en) begin
            if (gen_state == 8'd100) begin
                gen_state <= 8'd1;
                core_cnt  <= 0;
            end else if (core_cnt == CORE_LAT) begin
                gen_state  <= 8'd100;
                gen_result <= mt_nth(core_seed, core_k);
                core_k     <= core_k + 1;
                core_cnt   <= 0;
            end else begin
                gen_state <= 8'd1;
                core_cnt  <= core_cnt + 1;
            end
        end
    end

    task automatic push_exp(input int client);
        exp_t e;
        e.client = client;
        e.data   = mt_nth(ref_seed, ref_k);
        ref_k++;
        exp_q.push_back(e);
    endtask

    task automatic wait_deliver(output logic [NUM_REQ-1:0] vld, output logic [31:0] dat,
                                output bit timed_out);
        timed_out = 1'b1;
        vld = '0;
        dat = '0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (rsp_valid !== '0) begin
                vld = rsp_valid;
                dat = rsp_data;
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_gen_en(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < BUDGET && !seen; i++) begin
            @(negedge clk);
            if (gen_en === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req = '0;
        reseed_req = 1'b0;
        reseed_val = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, gen_rst, gen_en, rsp_valid, timeout_err} !== 8'b1100_0000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got busy/rst/en/vld/to=%b expected 11000000",
                     {busy, gen_rst, gen_en, rsp_valid, timeout_err});
        end
        vectors++;
        if (gen_seed !== 32'd200 || rsp_data !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_data: got seed=%0d data=%0h expected seed=200 data=0", gen_seed, rsp_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (gen_rst !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reseed_hold: got gen_rst=%b busy=%b expected 1 1", gen_rst, busy);
        end
        @(negedge clk);
        vectors++;
        if (gen_rst !== 1'b0 || busy !== 1'b0 || rsp_valid !== '0) begin
            miscompares++;
            $display("FAIL reseed_end: got gen_rst=%b busy=%b vld=%b expected 0 0 0000", gen_rst, busy, rsp_valid);
        end
        ref_seed = 32'd200;
        ref_k = 0;
    endtask

    task automatic test_single;
        logic [NUM_REQ-1:0] vld;
        logic [31:0] dat;
        bit to;
        bit extra;
        exp_t e;
        req = 4'b0001;
        push_exp(0);
        wait_deliver(vld, dat, to);
        req = '0;
        e = exp_q.pop_front();
        vectors++;
        if (to || vld !== (NUM_REQ'(1) << e.client) || dat !== e.data) begin
            miscompares++;
            $display("FAIL single: got to=%0b vld=%b data=%0h expected client %0d data=%0h",
                     to, vld, dat, e.client, e.data);
        end
        extra = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid !== '0) extra = 1'b1;
        end
        vectors++;
        if (extra || busy !== 1'b0 || rsp_data !== e.data) begin
            miscompares++;
            $display("FAIL single_after: got extra=%0b busy=%b data=%0h expected 0 0 %0h",
                     extra, busy, rsp_data, e.data);
        end
    endtask

    task automatic test_round_robin;
        logic [NUM_REQ-1:0] vld;
        logic [31:0] dat;
        bit to;
        exp_t e;
        // Previous delivery went to client 0, so the pointer now sits at 1.
        req = 4'b1111;
        for (int i = 0; i < 5; i++) push_exp((1 + i) % NUM_REQ);
        for (int i = 0; i < 5; i++) begin
            wait_deliver(vld, dat, to);
            if (i == 4) req = '0;
            e = exp_q.pop_front();
            vectors++;
            if (to || vld !== (NUM_REQ'(1) << e.client) || dat !== e.data) begin
                miscompares++;
                $display("FAIL rr_%0d: got to=%0b vld=%b data=%0h expected client %0d data=%0h",
                         i, to, vld, dat, e.client, e.data);
            end
        end
        repeat (10) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || rsp_valid !== '0) begin
            miscompares++;
            $display("FAIL rr_idle: got busy=%b vld=%b expected 0 0000", busy, rsp_valid);
        end
    endtask

    task automatic test_reseed_in_run;
        logic [NUM_REQ-1:0] vld;
        logic [31:0] dat;
        bit to;
        bit seen;
        exp_t e;
        req = 4'b0100;
        push_exp(2);
        wait_gen_en(seen);
        reseed_req = 1'b1;
        reseed_val = 32'd5489;
        @(negedge clk);
        reseed_req = 1'b0;
        reseed_val = 32'd0;
        wait_deliver(vld, dat, to);
        req = '0;
        e = exp_q.pop_front();
        vectors++;
        if (!seen || to || vld !== 4'b0100 || dat !== e.data) begin
            miscompares++;
            $display("FAIL reseed_cur: got en_seen=%0b to=%0b vld=%b data=%0h expected 1 0 0100 %0h",
                     seen, to, vld, dat, e.data);
        end
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (gen_rst === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (!seen || gen_seed !== 32'd5489) begin
            miscompares++;
            $display("FAIL reseed_seq: got rst_seen=%0b seed=%0d expected 1 5489", seen, gen_seed);
        end
        ref_seed = 32'd5489;
        ref_k = 1;
        e.client = 0;
        e.data = 32'd3499211612;
        exp_q.push_back(e);
        req = 4'b0001;
        wait_deliver(vld, dat, to);
        req = '0;
        e = exp_q.pop_front();
        vectors++;
        if (to || vld !== 4'b0001 || dat !== e.data) begin
            miscompares++;
            $display("FAIL reseed_word: got to=%0b vld=%b data=%0d expected 0001 %0d", to, vld, dat, e.data);
        end
    endtask

    task automatic test_reset_mid_run;
        logic [NUM_REQ-1:0] vld;
        logic [31:0] dat;
        bit to;
        bit seen;
        bit extra;
        exp_t e;
        repeat (3) @(negedge clk);
        req = 4'b1000;
        wait_gen_en(seen);
        rst_n = 1'b0;
        req = '0;
        #1;
        vectors++;
        if (!seen || {busy, gen_rst, gen_en, rsp_valid} !== 7'b1100_000 || gen_seed !== 32'd200) begin
            miscompares++;
            $display("FAIL async_rst: got en_seen=%0b busy/rst/en/vld=%b seed=%0d expected 1 1100000 200",
                     seen, {busy, gen_rst, gen_en, rsp_valid}, gen_seed);
        end
        extra = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid !== '0) extra = 1'b1;
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid !== '0) extra = 1'b1;
        end
        vectors++;
        if (extra || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_drop: got extra_vld=%0b busy=%b expected 0 0", extra, busy);
        end
        ref_seed = 32'd200;
        ref_k = 0;
        // Pointer is back at 0, so client 0 wins over client 3.
        req = 4'b1001;
        push_exp(0);
        wait_deliver(vld, dat, to);
        req = '0;
        e = exp_q.pop_front();
        vectors++;
        if (to || vld !== 4'b0001 || dat !== e.data) begin
            miscompares++;
            $display("FAIL rst_restart: got to=%0b vld=%b data=%0h expected 0001 %0h", to, vld, dat, e.data);
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_same_cycle_reseed;
        logic [NUM_REQ-1:0] vld;
        logic [31:0] dat;
        bit to;
        exp_t e;
        req = 4'b0010;
        reseed_req = 1'b1;
        reseed_val = 32'd5489;
        @(negedge clk);
        reseed_req = 1'b0;
        reseed_val = 32'd0;
        vectors++;
        if (gen_rst !== 1'b1 || gen_en !== 1'b0 || gen_seed !== 32'd5489) begin
            miscompares++;
            $display("FAIL reseed_first: got gen_rst=%b gen_en=%b seed=%0d expected 1 0 5489",
                     gen_rst, gen_en, gen_seed);
        end
        ref_seed = 32'd5489;
        ref_k = 1;
        e.client = 1;
        e.data = 32'd3499211612;
        exp_q.push_back(e);
        wait_deliver(vld, dat, to);
        req = '0;
        e = exp_q.pop_front();
        vectors++;
        if (to || vld !== 4'b0010 || dat !== e.data) begin
            miscompares++;
            $display("FAIL reseed_then_req: got to=%0b vld=%b data=%0d expected 0010 %0d", to, vld, dat, e.data);
        end
        repeat (10) @(negedge clk);
    endtask

`ifdef RNG_TIMEOUT_EN
    task automatic test_timeout;
        logic [NUM_REQ-1:0] vld;
        logic [31:0] dat;
        bit to;
        bit seen;
        exp_t e;
        core_stuck = 1'b1;
        req = 4'b0010;
        e.client = 1;
        e.data = 32'd0;
        exp_q.push_back(e);
        wait_deliver(vld, dat, to);
        req = '0;
        e = exp_q.pop_front();
        vectors++;
        if (to || vld !== 4'b0010 || dat !== e.data || timeout_err !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout: got to=%0b vld=%b data=%0h err=%b expected 0010 0 1", to, vld, dat, timeout_err);
        end
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (gen_rst === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (!seen || gen_seed !== 32'd5489) begin
            miscompares++;
            $display("FAIL timeout_reseed: got rst_seen=%0b seed=%0d expected 1 5489", seen, gen_seed);
        end
        core_stuck = 1'b0;
        repeat (5) @(negedge clk);
        ref_seed = 32'd5489;
        ref_k = 0;
        req = 4'b0100;
        push_exp(2);
        wait_deliver(vld, dat, to);
        req = '0;
        e = exp_q.pop_front();
        vectors++;
        if (to || vld !== 4'b0100 || dat !== e.data || timeout_err !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_recover: got to=%0b vld=%b data=%0h err=%b expected 0100 %0h 1",
                     to, vld, dat, timeout_err, e.data);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_reseed_in_run();
        test_reset_mid_run();
        test_same_cycle_reseed();
`ifdef RNG_TIMEOUT_EN
        test_timeout();
`else
        vectors++;
        if (timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_tied: got timeout_err=%b expected 0", timeout_err);
        end
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule : tb_rng_request_arbiter
